// File: rtl/trig_pipe_lut.sv
// Pipelined sine/cosine unit: quadrant fold onto a quarter-wave table, offset-binary output.
// Three stages share one advance enable so back-pressure freezes the whole pipe.
module trig_pipe_lut #(
    parameter int    PHASE_W  = 10,
    parameter int    VAL_W    = 10,
    parameter int    TAG_W    = 4,
    parameter string ROM_FILE = "qsin.hex"
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PHASE_W-1:0] in_phase,
    input  logic               in_iscos,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [VAL_W-1:0]   out_value,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int QW   = PHASE_W - 2;
    localparam int QD   = (1 << QW) + 1;
    localparam int IW   = PHASE_W - 1;
    localparam int MW   = VAL_W - 1;
    localparam int MID  = 1 << (VAL_W - 1);
    localparam int AMP  = MID - 1;
    localparam int FRAC = 60;

    // Q60 fixed-point arctan(1/m) series, used to derive pi/2 via Machin's formula.
    function automatic logic signed [127:0] atan_recip(input logic signed [127:0] m);
        logic signed [127:0] pw, sum, d;
        pw  = (128'sd1 <<< FRAC) / m;
        sum = pw;
        for (int unsigned n = 1; n < 32; n++) begin
            pw = pw / (m * m);
            d  = 128'(2 * n + 1);
            if (n[0]) sum = sum - pw / d;
            else      sum = sum + pw / d;
        end
        return sum;
    endfunction

    // Quarter-wave table T[k] = round(AMP*sin(k*pi/2/(QD-1))), evaluated at elaboration.
    function automatic logic [QD*MW-1:0] build_table();
        logic [QD*MW-1:0]    t;
        logic signed [127:0] hp, x, x2, term, sum, d, v;
        hp = 128'sd8 * atan_recip(128'sd5) - 128'sd2 * atan_recip(128'sd239);
        t  = '0;
        for (int unsigned k = 0; k < QD; k++) begin
            x    = hp * 128'(k) / 128'(QD - 1);
            x2   = (x * x) >>> FRAC;
            term = x;
            sum  = x;
            for (int unsigned n = 1; n <= 12; n++) begin
                d    = 128'(4 * n * n + 2 * n);
                term = -((term * x2) >>> FRAC) / d;
                sum  = sum + term;
            end
            v = (128'(AMP) * sum + (128'sd1 <<< (FRAC - 1))) >>> FRAC;
            t[k*MW +: MW] = MW'(v);
        end
        return t;
    endfunction

    localparam logic [QD*MW-1:0] QSIN = build_table();

    // The table is generated above rather than loaded; ROM_FILE stays so existing overrides elaborate.
    if (ROM_FILE == "") begin : g_no_rom_file
    end

    logic [MW-1:0] rom [QD];

    always_comb begin
        for (int unsigned i = 0; i < QD; i++) begin
            rom[i] = QSIN[i*MW +: MW];
        end
    end

    logic               adv;
    logic [PHASE_W-1:0] p;
    logic [1:0]         q;
    logic [QW-1:0]      k;
    logic [IW-1:0]      idx;

    logic               s1_valid;
    logic [IW-1:0]      s1_idx;
    logic               s1_neg;
    logic [TAG_W-1:0]   s1_tag;

    logic               s2_valid;
    logic [MW-1:0]      s2_mag;
    logic               s2_neg;
    logic [TAG_W-1:0]   s2_tag;

    logic [VAL_W-1:0]   s3_value;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_comb begin
        p   = in_phase + (in_iscos ? PHASE_W'(1 << QW) : '0);
        q   = p[PHASE_W-1 -: 2];
        k   = p[QW-1:0];
        idx = q[0] ? (IW'(QD - 1) - IW'(k)) : IW'(k);
    end

    // MID +/- AMP stays inside VAL_W bits, so no carry bit is kept.
    always_comb begin
        s3_value = s2_neg ? (VAL_W'(MID) - {1'b0, s2_mag})
                          : (VAL_W'(MID) + {1'b0, s2_mag});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_idx    <= '0;
            s1_neg    <= 1'b0;
            s1_tag    <= '0;
            s2_valid  <= 1'b0;
            s2_mag    <= '0;
            s2_neg    <= 1'b0;
            s2_tag    <= '0;
            out_valid <= 1'b0;
            out_value <= '0;
            out_tag   <= '0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s1_idx    <= idx;
            s1_neg    <= q[1];
            s1_tag    <= in_tag;
            s2_valid  <= s1_valid;
            s2_mag    <= rom[s1_idx];
            s2_neg    <= s1_neg;
            s2_tag    <= s1_tag;
            out_valid <= s2_valid;
            out_value <= s3_value;
            out_tag   <= s2_tag;
        end
    end

endmodule

// File: tb/tb_trig_pipe_lut.sv
// Directed-vector and sweep bench for trig_pipe_lut with an in-order expectation queue.
module tb_trig_pipe_lut;

    localparam int  MID = 512;
    localparam int  AMP = 511;
    localparam real PI  = 3.14159265358979323846;

    typedef struct {
        logic [9:0] ph;
        logic       cs;
        logic [3:0] tag;
        int         exp;
    } vec_t;

    typedef struct {
        int         exp;
        logic [3:0] tag;
        int         acc;
        bit         lat;
        bit         rec;
        int         ph;
        bit         cs;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] in_phase;
    logic       in_iscos;
    logic [3:0] in_tag;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_value;
    logic [3:0] out_tag;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_out   = 0;
    int   cyc     = 0;
    int   cur_exp = 0;
    bit   cur_lat = 1'b0;
    bit   cur_rec = 1'b0;
    ent_t exp_q[$];
    ent_t e;
    ent_t pe;
    bit   stall_prev = 1'b0;
    int   prev_val   = 0;
    int   prev_tag   = 0;
    int   sin_res [1024];
    int   cos_res [1024];
    vec_t vecs [15];

    trig_pipe_lut #(
        .PHASE_W (10),
        .VAL_W   (10),
        .TAG_W   (4),
        .ROM_FILE("qsin.hex")
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_phase (in_phase),
        .in_iscos (in_iscos),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_value(out_value),
        .out_tag  (out_tag)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d", name, act, req);
        end
    endtask

    function automatic int model(input int ph, input bit cs);
        real th, r;
        th = 2.0 * PI * real'(ph) / 1024.0;
        r  = real'(AMP) * (cs ? $cos(th) : $sin(th));
        if (r >= 0.0) return MID + int'($floor(r + 0.5));
        return MID - int'($floor(-r + 0.5));
    endfunction

    task automatic send(input logic [9:0] ph, input logic cs, input logic [3:0] tg,
                        input int ex, input bit lat, input bit rec);
        int w;
        in_valid = 1'b1;
        in_phase = ph;
        in_iscos = cs;
        in_tag   = tg;
        cur_exp  = ex;
        cur_lat  = lat;
        cur_rec  = rec;
        w = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            w++;
            if (w > 100) begin
                n_tests++;
                n_fail++;
                $display("FAIL accept_timeout: actual no accept after %0d cycles, required accept", w);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || out_valid) && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("drain_pending", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: checks the ready rule, stall stability and in-order results.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            chk("in_ready_rule", int'(in_ready), int'(!out_valid || out_ready));
            if (stall_prev) begin
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_value", int'(out_value), prev_val);
                chk("stall_tag", int'(out_tag), prev_tag);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: actual value %0d tag %0d, required no output",
                             out_value, out_tag);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("value ph=%0d cos=%0d", e.ph, e.cs), int'(out_value), e.exp);
                    chk($sformatf("tag ph=%0d", e.ph), int'(out_tag), int'(e.tag));
                    if (e.lat) chk("latency", cyc - e.acc, 3);
                    if (e.rec) begin
                        if (e.cs) cos_res[e.ph] = int'(out_value);
                        else      sin_res[e.ph] = int'(out_value);
                    end
                    n_out++;
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_val   = int'(out_value);
            prev_tag   = int'(out_tag);
            if (in_valid && in_ready) begin
                pe.exp = cur_exp;
                pe.tag = in_tag;
                pe.acc = cyc;
                pe.lat = cur_lat;
                pe.rec = cur_rec;
                pe.ph  = int'(in_phase);
                pe.cs  = in_iscos;
                exp_q.push_back(pe);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;

        vecs[0]  = '{10'd0,    1'b0, 4'd4,  512};
        vecs[1]  = '{10'd256,  1'b0, 4'd5,  1023};
        vecs[2]  = '{10'd512,  1'b0, 4'd6,  512};
        vecs[3]  = '{10'd768,  1'b0, 4'd7,  1};
        vecs[4]  = '{10'd0,    1'b1, 4'd1,  1023};
        vecs[5]  = '{10'd768,  1'b1, 4'd2,  512};
        vecs[6]  = '{10'd1023, 1'b1, 4'd3,  1023};
        vecs[7]  = '{10'd1,    1'b0, 4'd8,  515};
        vecs[8]  = '{10'd1023, 1'b0, 4'd9,  509};
        vecs[9]  = '{10'd513,  1'b0, 4'd10, 509};
        vecs[10] = '{10'd255,  1'b0, 4'd11, 1023};
        vecs[11] = '{10'd128,  1'b0, 4'd12, 873};
        vecs[12] = '{10'd640,  1'b0, 4'd13, 151};
        vecs[13] = '{10'd128,  1'b1, 4'd14, 873};
        vecs[14] = '{10'd64,   1'b0, 4'd15, 708};

        for (int i = 0; i < 1024; i++) begin
            sin_res[i] = -1000;
            cos_res[i] = -1000;
        end

        // Reset held with in_valid high: nothing may be accepted.
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_phase  = 10'd300;
        in_iscos  = 1'b0;
        in_tag    = 4'd9;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_value", int'(out_value), 0);
        chk("rst_out_tag", int'(out_tag), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        repeat (5) @(posedge clk);
        #1;
        chk("rst_no_output", int'(out_valid), 0);
        chk("rst_no_output_count", n_out, 0);

        // Directed table, back-to-back with out_ready held high.
        for (int i = 0; i < 15; i++) begin
            send(vecs[i].ph, vecs[i].cs, vecs[i].tag, vecs[i].exp, 1'b1, 1'b0);
        end
        in_valid = 1'b0;
        drain();
        chk("table_count", n_out, 15);

        // Back-pressure: 5-cycle stall in the middle of an 8-sample stream.
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(10'(i * 97 + 5), 1'b0, 4'(i), model(i * 97 + 5, 1'b0), 1'b0, 1'b0);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk);
                    chk("stall_in_ready", int'(in_ready), 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", n_out - n0, 8);

        // Reset with three samples in flight: none may emerge.
        n0 = n_out;
        out_ready = 1'b0;
        send(10'd100, 1'b0, 4'd1, model(100, 1'b0), 1'b0, 1'b0);
        send(10'd200, 1'b1, 4'd2, model(200, 1'b1), 1'b0, 1'b0);
        send(10'd300, 1'b0, 4'd3, model(300, 1'b0), 1'b0, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_value", int'(out_value), 0);
        chk("midrst_out_tag", int'(out_tag), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_no_output", n_out - n0, 0);
        chk("midrst_out_valid_late", int'(out_valid), 0);

        // Full sweep in both modes against the real-valued model.
        for (int ph = 0; ph < 1024; ph++) begin
            send(10'(ph), 1'b0, 4'(ph), model(ph, 1'b0), 1'b1, 1'b1);
        end
        for (int ph = 0; ph < 1024; ph++) begin
            send(10'(ph), 1'b1, 4'(ph), model(ph, 1'b1), 1'b1, 1'b1);
        end
        in_valid = 1'b0;
        drain();

        for (int ph = 0; ph < 1024; ph++) begin
            int s, c;
            s = sin_res[ph] - MID;
            c = cos_res[ph] - MID;
            if (s < 0) s = -s;
            if (c < 0) c = -c;
            chk($sformatf("sym_half ph=%0d", ph), sin_res[ph] + sin_res[(ph + 512) % 1024], 1024);
            chk($sformatf("sym_quarter ph=%0d", ph), cos_res[(ph + 256) % 1024], 1024 - sin_res[ph]);
            chk($sformatf("abs_sum ph=%0d", ph), int'(s + c >= AMP - 1), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
